// File: rtl/iserdes_test_sequencer.sv
// rtl/iserdes_test_sequencer.sv - per-lane ISERDES loopback reset/settle/check sequencer
module iserdes_test_sequencer #(
   parameter int LANES         = 10,
   parameter int RST_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 64,
   parameter int CHECK_CYCLES  = 1024,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [LANES-1:0]     ERROR,
   output logic [LANES-1:0]     LANE_RST,
   output logic [3:0]           CUR_LANE,
   output logic [CNT_WIDTH-1:0] ERR_CNT,
   output logic [LANES-1:0]     PASS,
   output logic                 BUSY,
   output logic                 DONE
);

   // The one shared down-counter must hold the longest phase length.
   localparam int MAX_RS = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int MAX_ALL = (MAX_RS > CHECK_CYCLES) ? MAX_RS : CHECK_CYCLES;
   localparam int TW = $clog2(MAX_ALL + 1);

   // Timer is loaded with length-1 so a phase lasts exactly its cycle count.
   localparam logic [TW-1:0]        T_RST    = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0]        T_SETTLE = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0]        T_CHECK  = TW'(CHECK_CYCLES - 1);
   localparam logic [TW-1:0]        T_ZERO   = '0;
   localparam logic [TW-1:0]        T_ONE    = TW'(1);
   localparam logic [LANES-1:0]     LANE0    = LANES'(1);
   localparam logic [3:0]           LAST     = 4'(LANES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LRST,
      S_SETTLE,
      S_CHECK,
      S_RECORD,
      S_DONE
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [LANES-1:0] lane_mask;
   logic            lane_err;

   // One-hot select of the lane under test; a shift avoids an oversized bit index.
   assign lane_mask = LANE0 << CUR_LANE;
   assign lane_err  = |(ERROR & lane_mask);

   // Sweep FSM: walks each lane through reset, settle, check and record.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= S_IDLE;
         timer    <= T_ZERO;
         LANE_RST <= '1;
         CUR_LANE <= 4'd0;
         ERR_CNT  <= CNT_ZERO;
         PASS     <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         case (state)
            // IDLE keeps all lanes in reset; DONE lets them free-run for the LEDs.
            S_IDLE, S_DONE: begin
               if (START) begin
                  state    <= S_LRST;
                  timer    <= T_RST;
                  LANE_RST <= '1;
                  CUR_LANE <= 4'd0;
                  ERR_CNT  <= CNT_ZERO;
                  PASS     <= '0;
                  BUSY     <= 1'b1;
                  DONE     <= 1'b0;
               end
            end
            S_LRST: begin
               if (timer == T_ZERO) begin
                  state    <= S_SETTLE;
                  timer    <= T_SETTLE;
                  LANE_RST <= ~lane_mask;
               end else begin
                  timer <= timer - T_ONE;
               end
            end
            // Errors during alignment are expected and deliberately not counted.
            S_SETTLE: begin
               if (timer == T_ZERO) begin
                  state <= S_CHECK;
                  timer <= T_CHECK;
               end else begin
                  timer <= timer - T_ONE;
               end
            end
            S_CHECK: begin
               if (lane_err && (ERR_CNT != CNT_MAX))
                  ERR_CNT <= ERR_CNT + 1'b1;
               if (timer == T_ZERO)
                  state <= S_RECORD;
               else
                  timer <= timer - T_ONE;
            end
            // Saturated counts are nonzero, so a saturated lane still fails.
            S_RECORD: begin
               if (ERR_CNT == CNT_ZERO)
                  PASS <= PASS | lane_mask;
               else
                  PASS <= PASS & ~lane_mask;
               if (CUR_LANE == LAST) begin
                  state    <= S_DONE;
                  BUSY     <= 1'b0;
                  DONE     <= 1'b1;
                  LANE_RST <= '0;
               end else begin
                  state    <= S_LRST;
                  timer    <= T_RST;
                  CUR_LANE <= CUR_LANE + 4'd1;
                  ERR_CNT  <= CNT_ZERO;
                  LANE_RST <= '1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iserdes_test_sequencer.sv
// tb/tb_iserdes_test_sequencer.sv - directed table-driven bench for iserdes_test_sequencer
module tb_iserdes_test_sequencer;

   logic       CLK;
   logic       RST;
   logic       START;
   logic [2:0] ERROR;
   logic [2:0] LANE_RST;
   logic [3:0] CUR_LANE;
   logic [2:0] ERR_CNT;
   logic [2:0] PASS;
   logic       BUSY;
   logic       DONE;

   int n_checks = 0;
   int n_fail   = 0;

   iserdes_test_sequencer #(
      .LANES(3),
      .RST_CYCLES(2),
      .SETTLE_CYCLES(4),
      .CHECK_CYCLES(8),
      .CNT_WIDTH(3)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .START(START),
      .ERROR(ERROR),
      .LANE_RST(LANE_RST),
      .CUR_LANE(CUR_LANE),
      .ERR_CNT(ERR_CNT),
      .PASS(PASS),
      .BUSY(BUSY),
      .DONE(DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One record: inputs held for n cycles, expected outputs after each edge.
   typedef struct {
      logic       start;
      logic [2:0] error;
      int         n;
      logic [2:0] lr;
      logic [3:0] cur;
      logic [2:0] ec;
      logic [2:0] pass;
      logic       busy;
      logic       done;
   } seg_t;

   seg_t segs[$];

   function automatic void add(input logic st, input logic [2:0] er, input int n,
                               input logic [2:0] lr, input logic [3:0] cur,
                               input logic [2:0] ec, input logic [2:0] pass,
                               input logic busy, input logic done);
      seg_t s;
      s.start = st; s.error = er; s.n = n; s.lr = lr; s.cur = cur;
      s.ec = ec; s.pass = pass; s.busy = busy; s.done = done;
      segs.push_back(s);
   endfunction

   // Error-free sweep: 1+1+13+2+13+2+13 = 45 busy cycles, then DONE.
   function automatic void add_clean(input logic hold, input int done_n);
      add(1'b1, 3'b000, 1,  3'b111, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(hold, 3'b000, 1,  3'b111, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(hold, 3'b000, 13, 3'b110, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(hold, 3'b000, 2,  3'b111, 4'd1, 3'd0, 3'b001, 1'b1, 1'b0);
      add(hold, 3'b000, 13, 3'b101, 4'd1, 3'd0, 3'b001, 1'b1, 1'b0);
      add(hold, 3'b000, 2,  3'b111, 4'd2, 3'd0, 3'b011, 1'b1, 1'b0);
      add(hold, 3'b000, 13, 3'b011, 4'd2, 3'd0, 3'b011, 1'b1, 1'b0);
      add(hold, 3'b000, done_n, 3'b000, 4'd2, 3'd0, 3'b111, 1'b0, 1'b1);
   endfunction

   task automatic chk(input string name, input logic [2:0] lr, input logic [3:0] cur,
                      input logic [2:0] ec, input logic [2:0] pass,
                      input logic busy, input logic done);
      n_checks++;
      if ({LANE_RST, CUR_LANE, ERR_CNT, PASS, BUSY, DONE} !== {lr, cur, ec, pass, busy, done}) begin
         n_fail++;
         $display("FAIL %s: got lane_rst=%b cur=%0d err_cnt=%0d pass=%b busy=%b done=%b, want lane_rst=%b cur=%0d err_cnt=%0d pass=%b busy=%b done=%b",
                  name, LANE_RST, CUR_LANE, ERR_CNT, PASS, BUSY, DONE,
                  lr, cur, ec, pass, busy, done);
      end
   endtask

   task automatic run_segs(input int first, input int last, input string name);
      for (int i = first; i < last; i++) begin
         for (int k = 0; k < segs[i].n; k++) begin
            START = segs[i].start;
            ERROR = segs[i].error;
            @(posedge CLK);
            #1;
            chk($sformatf("%s seg%0d cyc%0d", name, i, k), segs[i].lr, segs[i].cur,
                segs[i].ec, segs[i].pass, segs[i].busy, segs[i].done);
         end
      end
   endtask

   initial begin
      int s_clean0, s_err, s_sat, s_hold, s_clean1, s_end;

      s_clean0 = segs.size();
      add_clean(1'b0, 3);

      // Lane 1: ERROR[1] on 3 CHECK cycles, ERROR[0] across the window (ignored).
      // Lane 2: ERROR[2] only during SETTLE (masked).
      s_err = segs.size();
      add(1'b1, 3'b000, 1,  3'b111, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 1,  3'b111, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 13, 3'b110, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 2,  3'b111, 4'd1, 3'd0, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b000, 5,  3'b101, 4'd1, 3'd0, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b001, 1,  3'b101, 4'd1, 3'd0, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b011, 1,  3'b101, 4'd1, 3'd1, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b011, 1,  3'b101, 4'd1, 3'd2, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b011, 1,  3'b101, 4'd1, 3'd3, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b001, 4,  3'b101, 4'd1, 3'd3, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b000, 2,  3'b111, 4'd2, 3'd0, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b000, 1,  3'b011, 4'd2, 3'd0, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b100, 4,  3'b011, 4'd2, 3'd0, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b000, 8,  3'b011, 4'd2, 3'd0, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b000, 2,  3'b000, 4'd2, 3'd0, 3'b101, 1'b0, 1'b1);

      // Lane 0 errors on all 8 CHECK cycles: counter saturates at 7.
      s_sat = segs.size();
      add(1'b1, 3'b000, 1,  3'b111, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 1,  3'b111, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 5,  3'b110, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      for (int c = 1; c <= 7; c++)
         add(1'b0, 3'b001, 1, 3'b110, 4'd0, 3'(c), 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b001, 1,  3'b110, 4'd0, 3'd7, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 2,  3'b111, 4'd1, 3'd0, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 13, 3'b101, 4'd1, 3'd0, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 2,  3'b111, 4'd2, 3'd0, 3'b010, 1'b1, 1'b0);
      add(1'b0, 3'b000, 13, 3'b011, 4'd2, 3'd0, 3'b010, 1'b1, 1'b0);
      add(1'b0, 3'b000, 1,  3'b000, 4'd2, 3'd0, 3'b110, 1'b0, 1'b1);

      // START held: no effect while busy, restart on the first DONE cycle,
      // then run into lane 1's CHECK with ERROR[1] set.
      s_hold = segs.size();
      add_clean(1'b1, 1);
      add(1'b1, 3'b000, 1,  3'b111, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 1,  3'b111, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 13, 3'b110, 4'd0, 3'd0, 3'b000, 1'b1, 1'b0);
      add(1'b0, 3'b000, 2,  3'b111, 4'd1, 3'd0, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b000, 5,  3'b101, 4'd1, 3'd0, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b010, 1,  3'b101, 4'd1, 3'd1, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b010, 1,  3'b101, 4'd1, 3'd2, 3'b001, 1'b1, 1'b0);
      add(1'b0, 3'b010, 1,  3'b101, 4'd1, 3'd3, 3'b001, 1'b1, 1'b0);

      s_clean1 = segs.size();
      add_clean(1'b0, 3);
      s_end = segs.size();

      // Reset with START and ERROR active.
      RST = 1'b1; START = 1'b1; ERROR = 3'b111;
      #1;
      chk("reset t0", 3'b111, 4'd0, 3'd0, 3'b000, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge CLK); #1;
         chk("reset held", 3'b111, 4'd0, 3'd0, 3'b000, 1'b0, 1'b0);
      end
      RST = 1'b0; START = 1'b0; ERROR = 3'b000;
      repeat (8) begin
         @(posedge CLK); #1;
         chk("idle after reset", 3'b111, 4'd0, 3'd0, 3'b000, 1'b0, 1'b0);
      end

      run_segs(s_clean0, s_err, "clean");
      run_segs(s_err, s_sat, "errcount");
      run_segs(s_sat, s_hold, "saturate");
      run_segs(s_hold, s_clean1, "hold_start");

      // Mid-cycle reset during lane 1 CHECK: outputs clear before any clock edge.
      #3;
      RST = 1'b1; START = 1'b1;
      #1;
      chk("async reset", 3'b111, 4'd0, 3'd0, 3'b000, 1'b0, 1'b0);
      @(posedge CLK); #1;
      chk("reset mid held", 3'b111, 4'd0, 3'd0, 3'b000, 1'b0, 1'b0);
      RST = 1'b0; START = 1'b0; ERROR = 3'b000;
      repeat (5) begin
         @(posedge CLK); #1;
         chk("idle after mid reset", 3'b111, 4'd0, 3'd0, 3'b000, 1'b0, 1'b0);
      end

      run_segs(s_clean1, s_end, "restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/iserdes_test_sequencer.md
Name: iserdes_test_sequencer

Overview:
Sequences the ISERDES loopback test across N trx_path lanes, one lane at a time. For each lane it:
- holds the lane in reset, then releases it;
- waits a settle window while the ROM, serializer and receiver align;
- counts ERROR cycles over a fixed check window;
- latches a per-lane pass/fail bit.

It sits between the top-level clock/reset logic and the trx_path instances, and drives their per-lane resets and the status LEDs.

Parameters:
LANES, 10, number of trx_path lanes sequenced (1..16)
RST_CYCLES, 4, cycles a lane's reset is held asserted (>=1)
SETTLE_CYCLES, 64, cycles after reset release before errors are counted (>=1)
CHECK_CYCLES, 1024, length of the error-counting window (>=1)
CNT_WIDTH, 8, width of the saturating error counter

Ports:
CLK  input  1  system clock (divided test clock, same as trx_path CLK)
RST  input  1  asynchronous, active-high reset
START  input  1  level sampled each cycle; starts a full sweep when the block is IDLE or DONE
ERROR  input  LANES  per-lane comparator error from trx_path
LANE_RST  output  LANES  per-lane reset to trx_path, active-high
CUR_LANE  output  4  index of the lane under test
ERR_CNT  output  CNT_WIDTH  error-cycle count of the current or last tested lane
PASS  output  LANES  per-lane result; 1 = zero error cycles in the check window
BUSY  output  1  high while a sweep is in progress
DONE  output  1  high after a sweep completes, until the next START or RST

Behaviour:
- Reset (RST=1, asynchronous) and the values it forces: LANE_RST all ones, CUR_LANE=0, ERR_CNT=0, PASS=0, BUSY=0, DONE=0, state=IDLE, timer=0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, LRST, SETTLE, CHECK, RECORD, DONE.
- IDLE:
  - LANE_RST all ones.
  - START=1 -> LRST. On that edge: CUR_LANE=0, PASS=0, ERR_CNT=0, BUSY=1.
- LRST:
  - LANE_RST[CUR_LANE]=1; all other lanes are also 1.
  - Lasts exactly RST_CYCLES cycles, then -> SETTLE.
  - ERR_CNT is cleared on entry.
- SETTLE:
  - LANE_RST[CUR_LANE]=0; all other bits stay 1.
  - Lasts SETTLE_CYCLES cycles, then -> CHECK.
  - ERROR is ignored in this state.
- CHECK:
  - Lasts CHECK_CYCLES cycles.
  - On each cycle where ERROR[CUR_LANE]=1, ERR_CNT increments, saturating at 2^CNT_WIDTH-1.
  - Bits of ERROR other than ERROR[CUR_LANE] are ignored.
  - After the window -> RECORD.
- RECORD (1 cycle):
  - PASS[CUR_LANE] <= (ERR_CNT==0).
  - If CUR_LANE==LANES-1 -> DONE.
  - Otherwise CUR_LANE+1 and -> LRST.
- DONE:
  - BUSY=0, DONE=1.
  - LANE_RST all zeros, so every lane free-runs for LED display.
  - PASS, ERR_CNT and CUR_LANE are held.
  - START=1 -> same actions as the IDLE->LRST transition, and DONE=0.
- Per-lane duration is RST_CYCLES+SETTLE_CYCLES+CHECK_CYCLES+1 cycles.
  - DONE rises LANES x that duration cycles after the START edge.
- START is ignored while BUSY=1. A held START re-triggers a sweep on the first DONE cycle.
- One shared down-counter serves as the state timer. Its width is clog2 of max(RST_CYCLES, SETTLE_CYCLES, CHECK_CYCLES)+1.
- ERR_CNT saturation: it never wraps; a saturated count still forces PASS=0.
- RST asserted mid-sweep: all outputs return to reset values immediately. After release the block waits in IDLE for a new START and always restarts from lane 0.

Test Plan:
Use LANES=3, RST_CYCLES=2, SETTLE_CYCLES=4, CHECK_CYCLES=8, CNT_WIDTH=3 (per-lane duration 15 cycles, full sweep 45 cycles).
1. Reset check: assert RST with START=1 and ERROR=3'b111 -> LANE_RST=3'b111, PASS=0, BUSY=0, DONE=0, ERR_CNT=0, CUR_LANE=0. After RST release with START low -> the block stays in IDLE indefinitely.
2. Clean sweep: pulse START for 1 cycle, ERROR=0 throughout.
   - BUSY=1 for exactly 45 cycles, then DONE=1 and PASS=3'b111, LANE_RST=3'b000.
   - LANE_RST sequence seen: 111 for 2 cycles, 110 for 13, 111 for 2, 101 for 13, 111 for 2, 011 for 13.
3. Counted errors: ERROR[1]=1 for 3 cycles inside lane 1's CHECK, plus ERROR[0]=1 during lane 1's CHECK -> final PASS=3'b101. ERR_CNT=3 after lane 1's RECORD, then cleared to 0 on lane 2's LRST entry.
4. Settle masking and saturation:
   - ERROR[2]=1 throughout lane 2's SETTLE only -> PASS[2]=1.
   - Separate run: ERROR[0]=1 for all 8 CHECK cycles -> ERR_CNT=7 (saturated, no wrap), PASS[0]=0.
5. START handling: START held high continuously -> START pulses during BUSY have no effect. A new sweep begins on the first DONE cycle, which clears PASS to 0 and DONE to 0 on the following edge.
6. Mid-operation reset: assert RST during lane 1's CHECK -> outputs return to reset values asynchronously, without waiting for a CLK edge. After release and a START pulse, CUR_LANE=0 and the sweep completes in 45 cycles.
